// File: rtl/inst_mem_ctrl_if.sv
`timescale 1ns/1ps
// inst_mem_ctrl_if: fetch and program-load bus for inst_mem_ctrl.
//   master: fetch stage / program loader (drives fetch_req/addr, load_we/addr/data)
//   slave : inst_mem_ctrl (drives fetch_ready/valid/data/err, load_err, load_count)
interface inst_mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_err;
  logic                  load_we;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_err;
  logic [ADDR_WIDTH:0]   load_count;

  modport master (
    output fetch_req, fetch_addr, load_we, load_addr, load_data,
    input  fetch_ready, fetch_valid, fetch_data, fetch_err, load_err, load_count
  );

  modport slave (
    input  fetch_req, fetch_addr, load_we, load_addr, load_data,
    output fetch_ready, fetch_valid, fetch_data, fetch_err, load_err, load_count
  );
endinterface

// File: rtl/inst_mem_ctrl.sv
`timescale 1ns/1ps
// inst_mem_ctrl: loadable instruction memory with a 1-cycle fetch port and a
// program-load write port, with range checking and a saturating load counter.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : inst_mem_ctrl_if.slave (fetch req/addr/ready/valid/data/err,
//                load we/addr/data/err/count)
// Optional: define INSTMEM_INIT_EN to clear the array to NOP_WORD after reset
// (one word per cycle) before fetches and loads are accepted.
module inst_mem_ctrl #(
  parameter int unsigned           DATA_DEPTH = 1024,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  inst_mem_ctrl_if.slave  bus
);

  localparam int unsigned        IDX_W   = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int unsigned        CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DATA_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

`ifdef INSTMEM_INIT_EN
  typedef enum logic [0:0] {ST_READY = 1'b0, ST_INIT = 1'b1} state_e;
  localparam state_e           RST_STATE = ST_INIT;
  localparam logic [IDX_W-1:0] CLR_LAST  = IDX_W'(DATA_DEPTH - 1);
`else
  typedef enum logic [0:0] {ST_READY = 1'b0} state_e;
  localparam state_e RST_STATE = ST_READY;
`endif

  state_e                state_q, state_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic                  fetch_err_q, fetch_err_d;
  logic                  load_err_q, load_err_d;
  logic [CNT_W-1:0]      load_count_q, load_count_d;
`ifdef INSTMEM_INIT_EN
  logic [IDX_W-1:0]      clr_ptr_q, clr_ptr_d;
`endif

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic fetch_ready_c;
  logic fetch_in_range_c;
  logic load_in_range_c;

  // Widen by one bit so DATA_DEPTH == 2**ADDR_WIDTH compares as all-in-range.
  assign fetch_in_range_c = {1'b0, bus.fetch_addr} < DEPTH_C;
  assign load_in_range_c  = {1'b0, bus.load_addr}  < DEPTH_C;

  // A load owns the cycle, so a same-cycle read/write conflict never happens.
  assign fetch_ready_c = (state_q == ST_READY) && !bus.load_we;

  // Next-state, memory write port and registered output values.
  always_comb begin
    state_d       = state_q;
    fetch_valid_d = 1'b0;
    fetch_data_d  = fetch_data_q;
    fetch_err_d   = fetch_err_q;
    load_err_d    = 1'b0;
    load_count_d  = load_count_q;
    mem_we        = 1'b0;
    mem_waddr     = IDX_W'(bus.load_addr);
    mem_wdata     = bus.load_data;
`ifdef INSTMEM_INIT_EN
    clr_ptr_d     = clr_ptr_q;
`endif

    case (state_q)
      ST_READY: begin
        if (bus.load_we) begin
          if (load_in_range_c) begin
            mem_we = 1'b1;
            if (load_count_q != CNT_MAX) begin
              load_count_d = load_count_q + CNT_W'(1);
            end
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
`ifdef INSTMEM_INIT_EN
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = NOP_WORD;
        clr_ptr_d = clr_ptr_q + IDX_W'(1);
        load_err_d = bus.load_we;
        if (clr_ptr_q == CLR_LAST) begin
          clr_ptr_d = '0;
          state_d   = ST_READY;
        end
      end
`endif
      default: state_d = RST_STATE;
    endcase

    // Out-of-range fetches still answer, with NOP_WORD and the error flag.
    if (bus.fetch_req && fetch_ready_c) begin
      fetch_valid_d = 1'b1;
      fetch_err_d   = !fetch_in_range_c;
      fetch_data_d  = fetch_in_range_c ? mem[IDX_W'(bus.fetch_addr)] : NOP_WORD;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RST_STATE;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_err_q   <= 1'b0;
      load_err_q    <= 1'b0;
      load_count_q  <= '0;
`ifdef INSTMEM_INIT_EN
      clr_ptr_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      fetch_err_q   <= fetch_err_d;
      load_err_q    <= load_err_d;
      load_count_q  <= load_count_d;
`ifdef INSTMEM_INIT_EN
      clr_ptr_q     <= clr_ptr_d;
`endif
    end
  end

  // Storage array: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.fetch_ready = fetch_ready_c;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.load_err    = load_err_q;
  assign bus.load_count  = load_count_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
`timescale 1ns/1ps
// tb_inst_mem_ctrl: directed stimulus with a per-DUT expected-response queue
// checked by a negedge monitor. dut_a: 1024 x 32 (full 10-bit space),
// dut_b: 48 x 32 with 6-bit addresses, dut_c (INSTMEM_INIT_EN only): 16 x 32.
module tb_inst_mem_ctrl;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sbq [3][$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_mem_ctrl_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ifa ();
  inst_mem_ctrl_if #(.ADDR_WIDTH(6),  .DATA_WIDTH(32)) ifb ();

  inst_mem_ctrl #(.DATA_DEPTH(1024), .ADDR_WIDTH(10), .DATA_WIDTH(32), .NOP_WORD(32'h0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  inst_mem_ctrl #(.DATA_DEPTH(48), .ADDR_WIDTH(6), .DATA_WIDTH(32), .NOP_WORD(32'h0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

`ifdef INSTMEM_INIT_EN
  inst_mem_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ifc ();
  inst_mem_ctrl #(.DATA_DEPTH(16), .ADDR_WIDTH(4), .DATA_WIDTH(32), .NOP_WORD(32'h0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare one DUT's fetch response against the head of its queue.
  task automatic mon(input int idx, input logic v, input logic [31:0] d, input logic e);
    exp_t x;
    if (rst_n) begin
      if (sbq[idx].size() > 0 && sbq[idx][0].due == cyc) begin
        x = sbq[idx].pop_front();
        check($sformatf("dut%0d_fetch_valid", idx), 32'(v), 32'd1);
        check($sformatf("dut%0d_fetch_data", idx), d, x.data);
        check($sformatf("dut%0d_fetch_err", idx), 32'(e), 32'(x.err));
      end else if (v) begin
        check($sformatf("dut%0d_unexpected_valid", idx), 32'(v), 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.fetch_valid, ifa.fetch_data, ifa.fetch_err);
    mon(1, ifb.fetch_valid, ifb.fetch_data, ifb.fetch_err);
`ifdef INSTMEM_INIT_EN
    mon(2, ifc.fetch_valid, ifc.fetch_data, ifc.fetch_err);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response expected in the cycle after the coming accept edge.
  task automatic push(input int idx, input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.due  = cyc + 1;
    sbq[idx].push_back(x);
  endtask

  task automatic a_load(input logic [9:0] addr, input logic [31:0] data);
    ifa.load_we   = 1'b1;
    ifa.load_addr = addr;
    ifa.load_data = data;
    step();
    ifa.load_we   = 1'b0;
  endtask

  task automatic a_fetch(input logic [9:0] addr, input logic [31:0] exp);
    ifa.fetch_req  = 1'b1;
    ifa.fetch_addr = addr;
    #1;
    check("a_fetch_ready", 32'(ifa.fetch_ready), 32'd1);
    push(0, exp, 1'b0);
    step();
  endtask

  task automatic b_load(input logic [5:0] addr, input logic [31:0] data);
    ifb.load_we   = 1'b1;
    ifb.load_addr = addr;
    ifb.load_data = data;
    step();
    ifb.load_we   = 1'b0;
  endtask

  task automatic b_fetch(input logic [5:0] addr, input logic [31:0] exp, input logic err);
    ifb.fetch_req  = 1'b1;
    ifb.fetch_addr = addr;
    #1;
    push(1, exp, err);
    step();
    ifb.fetch_req  = 1'b0;
  endtask

`ifdef INSTMEM_INIT_EN
  task automatic wait_init();
    for (int k = 0; k < 1100 && !(ifa.fetch_ready && ifb.fetch_ready); k++) step();
    check("init_done", {30'd0, ifa.fetch_ready, ifb.fetch_ready}, 32'd3);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.fetch_req = 0; ifa.fetch_addr = '0; ifa.load_we = 0; ifa.load_addr = '0; ifa.load_data = '0;
    ifb.fetch_req = 0; ifb.fetch_addr = '0; ifb.load_we = 0; ifb.load_addr = '0; ifb.load_data = '0;
`ifdef INSTMEM_INIT_EN
    ifc.fetch_req = 0; ifc.fetch_addr = '0; ifc.load_we = 0; ifc.load_addr = '0; ifc.load_data = '0;
`endif
    #2;
    check("rst_fetch_valid", 32'(ifa.fetch_valid), 32'd0);
    check("rst_fetch_data", ifa.fetch_data, 32'd0);
    check("rst_fetch_err", 32'(ifa.fetch_err), 32'd0);
    check("rst_load_err", 32'(ifa.load_err), 32'd0);
    check("rst_load_count", 32'(ifa.load_count), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef INSTMEM_INIT_EN
    // 16-deep clear: ready low for 16 cycles, a load at cycle 3 is rejected.
    for (int k = 0; k < 16; k++) begin
      if (k == 3) ifc.load_we = 1'b1;
      #1;
      check($sformatf("c_init_ready_c%0d", k), 32'(ifc.fetch_ready), 32'd0);
      step();
      if (k == 3) begin
        ifc.load_we = 1'b0;
        check("c_init_load_err", 32'(ifc.load_err), 32'd1);
        check("c_init_load_count", 32'(ifc.load_count), 32'd0);
      end
    end
    #1;
    check("c_ready_after_init", 32'(ifc.fetch_ready), 32'd1);
    ifc.fetch_req  = 1'b1;
    ifc.fetch_addr = 4'd7;
    push(2, 32'h0, 1'b0);
    step();
    ifc.fetch_req  = 1'b0;
    wait_init();
`endif

    // Program load then back-to-back fetch.
    a_load(10'd0, 32'h3C014567);
    a_load(10'd1, 32'h00010C02);
    a_load(10'd2, 32'h3C010123);
    check("a_load_count_3", 32'(ifa.load_count), 32'd3);
    a_fetch(10'd0, 32'h3C014567);
    a_fetch(10'd1, 32'h00010C02);
    a_fetch(10'd2, 32'h3C010123);
    ifa.fetch_req = 1'b0;

    // Load and fetch in the same cycle: load wins, refetch sees the new word.
    a_load(10'd5, 32'h11112222);
    ifa.load_we    = 1'b1;
    ifa.load_addr  = 10'd5;
    ifa.load_data  = 32'h74392222;
    ifa.fetch_req  = 1'b1;
    ifa.fetch_addr = 10'd5;
    #1;
    check("a_collision_ready", 32'(ifa.fetch_ready), 32'd0);
    step();
    ifa.load_we = 1'b0;
    a_fetch(10'd5, 32'h74392222);
    ifa.fetch_req = 1'b0;
    check("a_load_count_5", 32'(ifa.load_count), 32'd5);
    step();

    // Partial-depth configuration: range errors.
    b_fetch(6'd50, 32'h0, 1'b1);
    b_load(6'd63, 32'hDEADBEEF);
    check("b_load63_err", 32'(ifb.load_err), 32'd1);
    check("b_load63_count", 32'(ifb.load_count), 32'd0);
    step();
    check("b_load_err_pulse_end", 32'(ifb.load_err), 32'd0);
    b_fetch(6'd63, 32'h0, 1'b1);
    b_load(6'd47, 32'hCAFEF00D);
    check("b_load47_err", 32'(ifb.load_err), 32'd0);
    b_fetch(6'd47, 32'hCAFEF00D, 1'b0);
    b_load(6'd48, 32'h12345678);
    check("b_load48_err", 32'(ifb.load_err), 32'd1);
    check("b_load_count_1", 32'(ifb.load_count), 32'd1);

    // Counter saturates at 2**7-1.
    for (int i = 0; i < 130; i++) b_load(6'(i % 48), 32'(i));
    check("b_load_count_sat", 32'(ifb.load_count), 32'd127);

    // Reset with a fetch response on the bus.
    ifa.fetch_req  = 1'b1;
    ifa.fetch_addr = 10'd1;
    push(0, 32'h00010C02, 1'b0);
    step();
    ifa.fetch_req = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) sbq[i].delete();
    #1;
    check("mid_rst_fetch_valid", 32'(ifa.fetch_valid), 32'd0);
    check("mid_rst_fetch_data", ifa.fetch_data, 32'd0);
    check("mid_rst_fetch_err", 32'(ifa.fetch_err), 32'd0);
    check("mid_rst_load_err", 32'(ifa.load_err), 32'd0);
    check("mid_rst_load_count", 32'(ifa.load_count), 32'd0);
    check("mid_rst_b_load_count", 32'(ifb.load_count), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
`ifdef INSTMEM_INIT_EN
    wait_init();
    a_fetch(10'd2, 32'h0);
`else
    a_fetch(10'd0, 32'h3C014567);
    a_fetch(10'd5, 32'h74392222);
`endif
    ifa.fetch_req = 1'b0;
    repeat (3) step();

    check("sb_drained", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
